// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor slice reused WIDTH times, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic             r_br;
  logic             r_borrow;
  logic [CNT_W-1:0] r_cnt;
`ifdef SERIAL_SUB_OVF_EN
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_ovf;
`endif

  logic             w_d_bit;
  logic             w_br_next;
  logic [WIDTH-1:0] w_res_next;

  function automatic logic sub_bit(input logic ai, input logic bi, input logic br);
    return ai ^ bi ^ br;
  endfunction

  function automatic logic sub_borrow(input logic ai, input logic bi, input logic br);
    return (~ai & bi) | (~(ai ^ bi) & br);
  endfunction

`ifdef SERIAL_SUB_OVF_EN
  // Operands of differing sign overflow when the result sign departs from the minuend's.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction
`endif

  assign w_d_bit    = sub_bit(r_a[0], r_b[0], r_br);
  assign w_br_next  = sub_borrow(r_a[0], r_b[0], r_br);
  assign w_res_next = {w_d_bit, r_res[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_diff   <= '0;
      r_br     <= 1'b0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
`ifdef SERIAL_SUB_OVF_EN
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_ovf    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
`endif
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_res <= w_res_next;
          r_br  <= w_br_next;
          r_cnt <= r_cnt + CNT_W'(1);
          // Last slice: publish the result and the borrow out of the MSB together.
          if (r_cnt == LAST_BIT) begin
            r_diff   <= w_res_next;
            r_borrow <= w_br_next;
`ifdef SERIAL_SUB_OVF_EN
            r_ovf    <= signed_ovf(r_a_msb, r_b_msb, w_d_bit);
`endif
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign busy       = (r_state == S_RUN);
  assign out_valid  = (r_state == S_DONE);
  assign diff       = r_diff;
  assign borrow_out = r_borrow;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf        = r_ovf;
`endif

endmodule
